// File: rtl/fetch_stage_if.sv
`default_nettype none
// =============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory, pipeline-control and D-register bundle
//               for the fetch stage.
// Revision    : 1.0
// =============================================================================
interface fetch_stage_if;
    logic [63:0] iaddr;
    logic [79:0] instr;
    logic        i_ok;
    logic        stall;
    logic        bubble;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;
    logic [2:0]  D_stat;
    logic        D_valid;

    modport master (
        output iaddr, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat, D_valid,
        input  instr, i_ok, stall, bubble, redirect, redirect_pc
    );

    modport slave (
        input  iaddr, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat, D_valid,
        output instr, i_ok, stall, bubble, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// =============================================================================
// Module      : fetch_stage
// Description : Y86-64 fetch stage: PC register, instruction decode, next-PC
//               prediction and the pipeline D register.
// Revision    : 1.0
// =============================================================================
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  wire logic      clock,
    input  wire logic      reset,
    fetch_stage_if.master  fif
);

    localparam logic [2:0] c_STAT_AOK = 3'd1;
    localparam logic [2:0] c_STAT_HLT = 3'd2;
    localparam logic [2:0] c_STAT_ADR = 3'd3;
    localparam logic [2:0] c_STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_HALTED   = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;

    logic [3:0]  r_d_icode, r_d_ifun, r_d_ra, r_d_rb;
    logic [63:0] r_d_valc, r_d_valp;
    logic [2:0]  r_d_stat;
    logic        r_d_valid;

    logic [7:0]  w_byte0, w_byte1;
    logic [3:0]  w_icode, w_ifun, w_ra, w_rb, w_len;
    logic [63:0] w_valc, w_valp, w_next_pc;
    logic [2:0]  w_stat;
    logic        w_load_bubble;

    // Next-D value: either the freshly decoded instruction or the nop bubble.
    logic [3:0]  w_d_icode, w_d_ifun, w_d_ra, w_d_rb;
    logic [63:0] w_d_valc, w_d_valp;
    logic [2:0]  w_d_stat;
    logic        w_d_valid;

    always_comb begin
        w_byte0 = fif.instr[7:0];
        w_byte1 = fif.instr[15:8];
        w_icode = w_byte0[7:4];
        w_ifun  = w_byte0[3:0];
        w_ra    = 4'hF;
        w_rb    = 4'hF;
        w_valc  = 64'h0;
        w_len   = 4'd1;
        case (w_icode)
            4'h2, 4'h6, 4'hA, 4'hB: begin
                w_ra  = w_byte1[7:4];
                w_rb  = w_byte1[3:0];
                w_len = 4'd2;
            end
            4'h3, 4'h4, 4'h5: begin
                w_ra   = w_byte1[7:4];
                w_rb   = w_byte1[3:0];
                w_valc = fif.instr[79:16];
                w_len  = 4'd10;
            end
            4'h7, 4'h8: begin
                w_valc = fif.instr[71:8];
                w_len  = 4'd9;
            end
            default: w_len = 4'd1;
        endcase

        w_valp = r_pc + {60'h0, w_len};

        if (!fif.i_ok)
            w_stat = c_STAT_ADR;
        else if (w_icode > 4'hB)
            w_stat = c_STAT_INS;
        else if (w_icode == 4'h0)
            w_stat = c_STAT_HLT;
        else
            w_stat = c_STAT_AOK;

        // Jumps and calls are predicted taken.
        w_next_pc = ((w_icode == 4'h7) || (w_icode == 4'h8)) ? w_valc : w_valp;

        w_load_bubble = fif.redirect || fif.bubble || (r_state != S_RUN);
        if (w_load_bubble) begin
            w_d_icode = 4'h1;
            w_d_ifun  = 4'h0;
            w_d_ra    = 4'hF;
            w_d_rb    = 4'hF;
            w_d_valc  = 64'h0;
            w_d_valp  = 64'h0;
            w_d_stat  = c_STAT_AOK;
            w_d_valid = 1'b0;
        end else begin
            w_d_icode = w_icode;
            w_d_ifun  = w_ifun;
            w_d_ra    = w_ra;
            w_d_rb    = w_rb;
            w_d_valc  = w_valc;
            w_d_valp  = w_valp;
            w_d_stat  = w_stat;
            w_d_valid = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_state   <= S_RUN;
            r_d_icode <= 4'h1;
            r_d_ifun  <= 4'h0;
            r_d_ra    <= 4'hF;
            r_d_rb    <= 4'hF;
            r_d_valc  <= 64'h0;
            r_d_valp  <= 64'h0;
            r_d_stat  <= c_STAT_AOK;
            r_d_valid <= 1'b0;
        end else if (fif.redirect || !fif.stall) begin
            r_d_icode <= w_d_icode;
            r_d_ifun  <= w_d_ifun;
            r_d_ra    <= w_d_ra;
            r_d_rb    <= w_d_rb;
            r_d_valc  <= w_d_valc;
            r_d_valp  <= w_d_valp;
            r_d_stat  <= w_d_stat;
            r_d_valid <= w_d_valid;
            if (fif.redirect) begin
                r_pc    <= fif.redirect_pc;
                r_state <= S_RUN;
            end else if (r_state == S_RUN) begin
                // PC/state follow the fetched instruction even when D is bubbled.
                if (w_stat != c_STAT_AOK)
                    r_state <= S_HALTED;
                else if (w_icode == 4'h9)
                    r_state <= S_RET_WAIT;
                else
                    r_pc <= w_next_pc;
            end
        end
    end

    assign fif.iaddr   = r_pc;
    assign fif.D_icode = r_d_icode;
    assign fif.D_ifun  = r_d_ifun;
    assign fif.D_rA    = r_d_ra;
    assign fif.D_rB    = r_d_rb;
    assign fif.D_valC  = r_d_valc;
    assign fif.D_valP  = r_d_valp;
    assign fif.D_stat  = r_d_stat;
    assign fif.D_valid = r_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// =============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0
// =============================================================================
module tb_fetch_stage;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;

    fetch_stage_if fif();

    fetch_stage #(.RESET_PC(64'h0)) dut (
        .clock (clock),
        .reset (reset),
        .fif   (fif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [79:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [63:0] c, input bit c_at1);
        if (c_at1)
            return {8'h00, c, b0};
        return {c, b1, b0};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [3:0] icode, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] valc, input logic [63:0] valp,
                         input logic [2:0] stat, input logic valid, input logic [63:0] iaddr);
        chk({tag, ".icode"}, {60'h0, fif.D_icode}, {60'h0, icode});
        chk({tag, ".rA"},    {60'h0, fif.D_rA},    {60'h0, ra});
        chk({tag, ".rB"},    {60'h0, fif.D_rB},    {60'h0, rb});
        chk({tag, ".valC"},  fif.D_valC,           valc);
        chk({tag, ".valP"},  fif.D_valP,           valp);
        chk({tag, ".stat"},  {61'h0, fif.D_stat},  {61'h0, stat});
        chk({tag, ".valid"}, {63'h0, fif.D_valid}, {63'h0, valid});
        chk({tag, ".iaddr"}, fif.iaddr,            iaddr);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        fif.instr       = 80'h0;
        fif.i_ok        = 1'b1;
        fif.stall       = 1'b0;
        fif.bubble      = 1'b0;
        fif.redirect    = 1'b0;
        fif.redirect_pc = 64'h0;
        step();
        step();
        chk_d("reset", 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 1'b0, 64'h0);

        // irmovq $10, %rbx at PC 0
        reset = 1'b0;
        fif.instr = mk(8'h30, 8'hF3, 64'd10, 1'b0);
        step();
        chk_d("irmovq", 4'h3, 4'hF, 4'h3, 64'd10, 64'd10, 3'd1, 1'b1, 64'd10);

        // jump at 0x20 predicted taken, then corrected to fall-through
        fif.redirect = 1'b1; fif.redirect_pc = 64'h20;
        step();
        chk("redir20.iaddr", fif.iaddr, 64'h20);
        fif.redirect = 1'b0;
        fif.instr = mk(8'h70, 8'h00, 64'h100, 1'b1);
        step();
        chk_d("jmp", 4'h7, 4'hF, 4'hF, 64'h100, 64'h29, 3'd1, 1'b1, 64'h100);
        fif.redirect = 1'b1; fif.redirect_pc = 64'h29;
        step();
        chk_d("redir29", 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 1'b0, 64'h29);

        // ret at 0x29 stalls fetch until resolved
        fif.redirect = 1'b0;
        fif.instr = mk(8'h90, 8'h00, 64'h0, 1'b0);
        step();
        chk_d("ret", 4'h9, 4'hF, 4'hF, 64'h0, 64'h2A, 3'd1, 1'b1, 64'h29);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_d("retwait", 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 1'b0, 64'h29);
        end
        fif.redirect = 1'b1; fif.redirect_pc = 64'h40;
        step();
        chk("redir40.iaddr", fif.iaddr, 64'h40);
        fif.redirect = 1'b0;
        fif.instr = mk(8'h20, 8'h12, 64'h0, 1'b0);
        step();
        chk_d("rrmovq", 4'h2, 4'h1, 4'h2, 64'h0, 64'h42, 3'd1, 1'b1, 64'h42);

        // bad address halts fetch
        fif.i_ok = 1'b0;
        step();
        chk("adr.stat", {61'h0, fif.D_stat}, 64'd3);
        chk("adr.iaddr", fif.iaddr, 64'h42);
        fif.i_ok = 1'b1;
        fif.instr = mk(8'h60, 8'h01, 64'h0, 1'b0);
        step();
        chk_d("adr.halted", 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 1'b0, 64'h42);

        // reset from HALTED, then illegal opcode
        reset = 1'b1;
        step();
        chk("rst_halt.iaddr", fif.iaddr, 64'h0);
        reset = 1'b0;
        fif.instr = mk(8'hC0, 8'h00, 64'h0, 1'b0);
        step();
        chk("ins.stat", {61'h0, fif.D_stat}, 64'd4);
        chk("ins.iaddr", fif.iaddr, 64'h0);

        // halt instruction
        reset = 1'b1;
        step();
        reset = 1'b0;
        fif.instr = mk(8'h00, 8'h00, 64'h0, 1'b0);
        step();
        chk("hlt.stat", {61'h0, fif.D_stat}, 64'd2);
        chk("hlt.icode", {60'h0, fif.D_icode}, 64'h0);
        chk("hlt.iaddr", fif.iaddr, 64'h0);
        fif.instr = mk(8'h10, 8'h00, 64'h0, 1'b0);
        step();
        chk_d("hlt.frozen", 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 1'b0, 64'h0);

        // stall dominates bubble; bubble alone still advances the PC
        fif.redirect = 1'b1; fif.redirect_pc = 64'h80;
        step();
        chk("redir80.iaddr", fif.iaddr, 64'h80);
        fif.redirect = 1'b0;
        fif.instr = mk(8'h60, 8'h23, 64'h0, 1'b0);
        step();
        chk_d("addq", 4'h6, 4'h2, 4'h3, 64'h0, 64'h82, 3'd1, 1'b1, 64'h82);
        fif.stall = 1'b1; fif.bubble = 1'b1;
        fif.instr = mk(8'h30, 8'hF4, 64'd5, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk_d("stall", 4'h6, 4'h2, 4'h3, 64'h0, 64'h82, 3'd1, 1'b1, 64'h82);
        end
        fif.stall = 1'b0;
        step();
        chk_d("bubble", 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 1'b0, 64'h8C);

        // redirect overrides stall
        fif.bubble = 1'b0; fif.stall = 1'b1;
        fif.redirect = 1'b1; fif.redirect_pc = 64'h200;
        step();
        chk("redir_stall.iaddr", fif.iaddr, 64'h200);
        chk("redir_stall.valid", {63'h0, fif.D_valid}, 64'h0);

        // valP wraps modulo 2^64
        fif.stall = 1'b0;
        fif.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        fif.redirect = 1'b0;
        fif.instr = mk(8'h10, 8'h00, 64'h0, 1'b0);
        step();
        chk_d("wrap", 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 1'b1, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
